ov7670_stream_gen: RTL and testbench

Synthetic OV7670 pixel-bus transmitter: drives PCLK/VSYNC/HREF/D[7:0] with the sensor's frame timing and a known byte pattern, so the camera capture path and SPRAM frame buffer can be exercised on hardware and in simulation without a sensor fitted. Sits on the 25 MHz PLL clock domain and connects, in place of the camera pins, to the capture receiver's `p_clock`/`vsync`/`href`/`p_data` inputs.

---
 rtl/ov7670_stream_gen.sv | 193 +++++++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_stream_gen.sv
// Synthetic OV7670 pixel-bus source: PCLK/VSYNC/HREF/D with sensor frame timing.
// Define OV_STREAM_COLORBAR_EN for RGB565 colour bars instead of the byte ramp.
module ov7670_stream_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] data,
    output logic [7:0] frame_count,
    output logic       busy
);
    localparam logic [10:0] BYTE_LAST = 11'(2 * H_ACTIVE + H_BLANK - 1);
    localparam logic [10:0] HREF_END  = 11'(2 * H_ACTIVE);
    localparam logic [9:0]  VS_LAST   = 10'(VSYNC_LINES - 1);
    localparam logic [9:0]  VB_LAST   = 10'(V_BACK - 1);
    localparam logic [9:0]  VA_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  VF_LAST   = 10'(V_FRONT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t      state_q, state_d;
    logic        pclk_q;
    logic [10:0] byte_q, byte_d;
    logic [9:0]  line_q, line_d, line_last;
    logic [7:0]  fc_q, fc_d;
    logic [7:0]  data_q, data_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic        busy_q, busy_d;
    logic        clr;

`ifdef OV_STREAM_COLORBAR_EN
    localparam logic [9:0] BAR_LAST = 10'(H_ACTIVE / 8 - 1);

    logic        lo_q, lo_d, lo_b;
    logic [9:0]  bpix_q, bpix_d, bpix_b;
    logic [2:0]  bar_q, bar_d, bar_b;
    logic [15:0] col;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        unique case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction
`else
    logic [7:0]  dcnt_q, dcnt_d, dcnt_b;
`endif

    // Frame sequencing; only committed on update edges (pclk 1->0).
    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        line_d  = line_q;
        fc_d    = fc_q;
        unique case (state_q)
            S_VBACK:  line_last = VB_LAST;
            S_ACTIVE: line_last = VA_LAST;
            S_VFRONT: line_last = VF_LAST;
            default:  line_last = VS_LAST;
        endcase
        if (state_q == S_IDLE) begin
            if (enable) begin
                state_d = S_VSYNC;
                byte_d  = '0;
                line_d  = '0;
            end
        end else if (byte_q != BYTE_LAST) begin
            byte_d = byte_q + 11'd1;
        end else begin
            byte_d = '0;
            line_d = line_q + 10'd1;
            if (line_q == line_last) begin
                line_d = '0;
                unique case (state_q)
                    S_VSYNC:  state_d = S_VBACK;
                    S_VBACK:  state_d = S_ACTIVE;
                    S_ACTIVE: state_d = S_VFRONT;
                    default: begin
                        state_d = enable ? S_VSYNC : S_IDLE;
                        fc_d    = fc_q + 8'd1;
                    end
                endcase
            end
        end
    end

    assign clr = (state_d != state_q);

    always_comb begin
        vsync_d = (state_d == S_VSYNC);
        href_d  = (state_d == S_ACTIVE) && (byte_d < HREF_END);
        busy_d  = (state_d != S_IDLE);
        data_d  = 8'h00;
`ifdef OV_STREAM_COLORBAR_EN
        lo_b   = clr ? 1'b0 : lo_q;
        bpix_b = clr ? 10'd0 : bpix_q;
        bar_b  = clr ? 3'd0 : bar_q;
        lo_d   = lo_b;
        bpix_d = bpix_b;
        bar_d  = bar_b;
        col    = bar_color(bar_b);
        if (href_d) begin
            data_d = lo_b ? col[7:0] : col[15:8];
            lo_d   = ~lo_b;
            // Bar index wraps 7->0 exactly at end of line.
            if (lo_b) begin
                if (bpix_b == BAR_LAST) begin
                    bpix_d = '0;
                    bar_d  = bar_b + 3'd1;
                end else begin
                    bpix_d = bpix_b + 10'd1;
                end
            end
        end
`else
        dcnt_b = clr ? 8'd0 : dcnt_q;
        dcnt_d = dcnt_b;
        if (href_d) begin
            data_d = dcnt_b;
            dcnt_d = dcnt_b + 8'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk_q  <= 1'b0;
            state_q <= S_IDLE;
            byte_q  <= '0;
            line_q  <= '0;
            fc_q    <= '0;
            data_q  <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef OV_STREAM_COLORBAR_EN
            lo_q    <= 1'b0;
            bpix_q  <= '0;
            bar_q   <= '0;
`else
            dcnt_q  <= '0;
`endif
        end else begin
            pclk_q <= ~pclk_q;
            if (pclk_q) begin
                state_q <= state_d;
                byte_q  <= byte_d;
                line_q  <= line_d;
                fc_q    <= fc_d;
                data_q  <= data_d;
                vsync_q <= vsync_d;
                href_q  <= href_d;
                busy_q  <= busy_d;
`ifdef OV_STREAM_COLORBAR_EN
                lo_q    <= lo_d;
                bpix_q  <= bpix_d;
                bar_q   <= bar_d;
`else
                dcnt_q  <= dcnt_d;
`endif
            end
        end
    end

    assign pclk        = pclk_q;
    assign vsync       = vsync_q;
    assign href        = href_q;
    assign data        = data_q;
    assign frame_count = fc_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen: per-PCLK-period stream compared to a frame model.
// Works with or without OV_STREAM_COLORBAR_EN defined.
module tb_ov7670_stream_gen;
    localparam int H  = 16;
    localparam int VA = 4;
    localparam int HB = 4;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int L  = 2 * H + HB;
    localparam int FR = (VS + VB + VA + VF) * L;
    localparam int H2 = 160;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       enable = 1'b0;
    logic       en2    = 1'b0;
    logic       pclk, vsync, href, busy;
    logic [7:0] data, frame_count;
    logic       pclk2, vsync2, href2, busy2;
    logic [7:0] data2, fc2;

    int checks    = 0;
    int failures  = 0;
    int phase_err = 0;
    int stab_err  = 0;

    always #5 clk = ~clk;

    ov7670_stream_gen #(
        .H_ACTIVE(H), .V_ACTIVE(VA), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .pclk(pclk), .vsync(vsync), .href(href), .data(data),
        .frame_count(frame_count), .busy(busy)
    );

    ov7670_stream_gen #(
        .H_ACTIVE(H2), .V_ACTIVE(2), .H_BLANK(4),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en2),
        .pclk(pclk2), .vsync(vsync2), .href(href2), .data(data2),
        .frame_count(fc2), .busy(busy2)
    );

    // Expected byte of an active line: ramp or colour bars.
    function automatic logic [7:0] exp_byte(input int h, input int aline, input int pos);
`ifdef OV_STREAM_COLORBAR_EN
        int bar;
        logic [15:0] c;
        bar = (pos / 2) / (h / 8);
        case (bar)
            0: c = 16'hFFFF;
            1: c = 16'hFFE0;
            2: c = 16'h07FF;
            3: c = 16'h07E0;
            4: c = 16'hF81F;
            5: c = 16'hF800;
            6: c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return (pos % 2 == 0) ? c[15:8] : c[7:0];
`else
        return 8'((aline * 2 * h + pos) % 256);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after an update edge; returns values seen at the pclk rise.
    task automatic sample_period(output logic v, output logic h, output logic b,
                                 output logic [7:0] d, output logic [7:0] f);
        logic [18:0] a;
        a = {vsync, href, busy, data, frame_count};
        @(posedge clk); #1;
        if (pclk !== 1'b1) phase_err++;
        if ({vsync, href, busy, data, frame_count} !== a) stab_err++;
        v = vsync; h = href; b = busy; d = data; f = frame_count;
        @(posedge clk); #1;
        if (pclk !== 1'b0) phase_err++;
    endtask

    task automatic check_frame(input int fc, input int drop_k);
        logic v, h, b, ev, eh, hprev;
        logic [7:0] d, f, ed;
        logic [18:0] fo, fe;
        int line, pos, bad, fk, vs_n, hp_n, hlen, hbad;
        bad = 0; fk = -1; vs_n = 0; hp_n = 0; hlen = 0; hbad = 0;
        hprev = 1'b0; fo = '0; fe = '0;
        for (int k = 0; k < FR; k++) begin
            sample_period(v, h, b, d, f);
            if (k == drop_k) enable = 1'b0;
            line = k / L;
            pos  = k % L;
            ev = (line < VS);
            eh = (line >= VS + VB) && (line < VS + VB + VA) && (pos < 2 * H);
            ed = 8'h00;
            if (eh) ed = exp_byte(H, line - VS - VB, pos);
            if ({v, h, b, d, f} !== {ev, eh, 1'b1, ed, 8'(fc)}) begin
                if (bad == 0) begin
                    fk = k;
                    fo = {v, h, b, d, f};
                    fe = {ev, eh, 1'b1, ed, 8'(fc)};
                end
                bad++;
            end
            if (v) vs_n++;
            if (h && !hprev) hp_n++;
            if (h) hlen++;
            if (!h && hprev) begin
                if (hlen != 2 * H) hbad++;
                hlen = 0;
            end
            hprev = h;
        end
        if (bad != 0)
            $display("  frame %0d first divergence at period %0d: got %h want %h",
                     fc, fk, fo, fe);
        chk("frame_stream_bad_periods", bad, 0);
        chk("vsync_high_periods", vs_n, VS * L);
        chk("href_pulses", hp_n, VA);
        chk("href_width_errors", hbad, 0);
    endtask

    initial begin
        int lat, tog_bad, zero_bad, drop_k, n, idle_bad;
        logic pprev, sv, sh, sb;
        logic [7:0] sd, sf;

        // Reset and idle behaviour
        repeat ($urandom_range(3, 10)) @(negedge clk);
        chk("rst_pclk", 32'(pclk), 0);
        chk("rst_vsync", 32'(vsync), 0);
        chk("rst_href", 32'(href), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_frame_count", 32'(frame_count), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_pclk_rise", 32'(pclk), 1);
        tog_bad = 0; zero_bad = 0; pprev = pclk;
        repeat (100) begin
            @(posedge clk); #1;
            if (pclk === pprev) tog_bad++;
            pprev = pclk;
            if ({vsync, href, busy, data, frame_count} !== 19'd0) zero_bad++;
        end
        chk("idle_pclk_toggle_errors", tog_bad, 0);
        chk("idle_outputs_nonzero", zero_bad, 0);

        // Three back-to-back frames
        repeat ($urandom_range(0, 5)) @(negedge clk);
        enable = 1'b1;
        lat = 0;
        while (vsync !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("enable_to_vsync_le2", 32'(lat <= 2), 1);
        for (int fr = 0; fr < 3; fr++) check_frame(fr, -1);
        sample_period(sv, sh, sb, sd, sf);
        chk("frame_count_after_3", 32'(sf), 3);
        chk("vsync_at_frame4", 32'(sv), 1);

        // Asynchronous reset in the middle of an href pulse
        n = 0;
        while (sh !== 1'b1 && n < 300) begin
            sample_period(sv, sh, sb, sd, sf);
            n++;
        end
        repeat ($urandom_range(0, 25)) sample_period(sv, sh, sb, sd, sf);
        @(posedge clk); #2;
        chk("href_before_reset", 32'(href), 1);
        rst_n = 1'b0;
        #1;
        chk("midline_rst_pclk", 32'(pclk), 0);
        chk("midline_rst_href", 32'(href), 0);
        chk("midline_rst_vsync", 32'(vsync), 0);
        chk("midline_rst_busy", 32'(busy), 0);
        chk("midline_rst_data", 32'(data), 0);
        chk("midline_rst_frame_count", 32'(frame_count), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rerelease_pclk_rise", 32'(pclk), 1);
        lat = 1;
        while (vsync !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("restart_vsync_latency", lat, 2);

        // Enable dropped during the second active line: frame still completes
        drop_k = (VS + VB + 1) * L + $urandom_range(0, L - 1);
        check_frame(0, drop_k);
        sample_period(sv, sh, sb, sd, sf);
        chk("drop_frame_count", 32'(sf), 1);
        chk("drop_busy_fell", 32'(sb), 0);
        chk("drop_vsync_low", 32'(sv), 0);
        idle_bad = 0;
        repeat (600) begin
            @(posedge clk); #1;
            if (vsync !== 1'b0 || busy !== 1'b0 || href !== 1'b0) idle_bad++;
        end
        chk("drop_no_restart", idle_bad, 0);

        // Wide line: byte counter wraps inside line 0
        @(negedge clk);
        en2 = 1'b1;
        n = 0;
        while (href2 !== 1'b1 && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("h160_href_seen", 32'(href2), 1);
        chk("h160_byte0", 32'(data2), 32'(exp_byte(H2, 0, 0)));
        repeat (510) @(posedge clk);
        #1;
        chk("h160_byte255", 32'(data2), 32'(exp_byte(H2, 0, 255)));
        repeat (2) @(posedge clk);
        #1;
        chk("h160_byte256", 32'(data2), 32'(exp_byte(H2, 0, 256)));
        chk("h160_href_still_high", 32'(href2), 1);
        chk("h160_busy", 32'(busy2), 1);
        chk("h160_vsync_low", 32'(vsync2), 0);
        chk("h160_frame_count", 32'(fc2), 0);
        chk("h160_pclk_phase", 32'(pclk2), 32'(pclk));

        chk("pclk_phase_errors", phase_err, 0);
        chk("unstable_at_pclk_rise", stab_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
